// File: rtl/max_pool_engine.sv
//==============================================================================
// Module   : max_pool_engine
// Purpose  : Max pooling over the KxK window stream of an upstream
//            sliding_window. Windows that straddle a row boundary are
//            dropped and a configurable stride is applied. Each accepted
//            window goes through a two-stage registered comparator tree
//            and produces one pooled pixel with an end-of-frame marker.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-high reset
//            window       - current window, window[r][c], row 0 = oldest row
//            window_valid - window populated; one raster step per assertion
//            pool_out     - maximum of an accepted window
//            pool_valid   - pool_out valid this cycle
//            pool_last    - final pooled pixel of the frame (with pool_valid)
// Config   : MAXPOOL_SIGNED_EN - when defined, pixels compare as
//            two's-complement signed; otherwise unsigned.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module max_pool_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3,
  parameter int ROW_SIZE   = 5,
  parameter int STRIDE     = 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][DATA_WIDTH-1:0] window,
  input  logic                                                window_valid,
  output logic [DATA_WIDTH-1:0]                               pool_out,
  output logic                                                pool_valid,
  output logic                                                pool_last
);

  localparam int OUT_DIM = (ROW_SIZE - KERNEL_DIM) / STRIDE + 1;
  localparam int CNT_W   = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int PH_W    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CNT_W-1:0] C_FIRST    = CNT_W'(KERNEL_DIM - 1);
  localparam logic [CNT_W-1:0] C_EDGE     = CNT_W'(ROW_SIZE - 1);
  localparam logic [CNT_W-1:0] C_LAST_POS = CNT_W'(KERNEL_DIM - 1 + (OUT_DIM - 1) * STRIDE);
  localparam logic [PH_W-1:0]  C_PH_MAX   = PH_W'(STRIDE - 1);

  if (ROW_SIZE < KERNEL_DIM || STRIDE < 1 || KERNEL_DIM < 1) begin : g_param_check
    $error("max_pool_engine: requires ROW_SIZE >= KERNEL_DIM >= 1 and STRIDE >= 1");
  end

  // Pixel comparison; the only place where signedness matters.
  function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Position and stride-phase tracking
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [PH_W-1:0]  col_ph_q,  col_ph_d;
  logic [PH_W-1:0]  row_ph_q,  row_ph_d;
  logic             accept;
  logic             accept_last;

  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    col_ph_d  = col_ph_q;
    row_ph_d  = row_ph_q;
    if (window_valid) begin
      if (col_cnt_q == C_EDGE) begin
        col_cnt_d = '0;
        if (row_cnt_q == C_EDGE) begin
          // Frame complete: next pixel is the first of a new frame.
          row_cnt_d = C_FIRST;
          row_ph_d  = '0;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
          row_ph_d  = (row_ph_q == C_PH_MAX) ? '0 : row_ph_q + 1'b1;
        end
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
      // Column phase restarts at the first full-window column of every row,
      // so stride alignment never depends on row length.
      if (col_cnt_d == C_FIRST) begin
        col_ph_d = '0;
      end else begin
        col_ph_d = (col_ph_q == C_PH_MAX) ? '0 : col_ph_q + 1'b1;
      end
    end
  end

  assign accept = window_valid && (col_cnt_q >= C_FIRST) &&
                  (col_ph_q == '0) && (row_ph_q == '0);
  assign accept_last = accept && (row_cnt_q == C_LAST_POS) && (col_cnt_q == C_LAST_POS);

  // ---------------------------------------------------------------------------
  // Comparator tree
  // ---------------------------------------------------------------------------
  logic [KERNEL_DIM-1:0][DATA_WIDTH-1:0] row_max_d, row_max_q;
  logic [DATA_WIDTH-1:0]                 pool_max_d;
  logic                                  s1_valid_q, s1_last_q;
  logic [DATA_WIDTH-1:0]                 pool_out_q;
  logic                                  pool_valid_q, pool_last_q;

  always_comb begin
    row_max_d = '0;
    for (int r = 0; r < KERNEL_DIM; r++) begin
      row_max_d[r] = window[r][0];
      for (int c = 1; c < KERNEL_DIM; c++) begin
        if (greater(window[r][c], row_max_d[r])) begin
          row_max_d[r] = window[r][c];
        end
      end
    end
  end

  always_comb begin
    pool_max_d = row_max_q[0];
    for (int r = 1; r < KERNEL_DIM; r++) begin
      if (greater(row_max_q[r], pool_max_d)) begin
        pool_max_d = row_max_q[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q    <= C_FIRST;
      row_cnt_q    <= C_FIRST;
      col_ph_q     <= '0;
      row_ph_q     <= '0;
      row_max_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      pool_last_q  <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      col_ph_q     <= col_ph_d;
      row_ph_q     <= row_ph_d;
      row_max_q    <= row_max_d;
      s1_valid_q   <= accept;
      s1_last_q    <= accept_last;
      pool_out_q   <= pool_max_d;
      pool_valid_q <= s1_valid_q;
      pool_last_q  <= s1_last_q;
    end
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;
  assign pool_last  = pool_last_q;

endmodule

`default_nettype wire

// File: tb/tb_max_pool_engine.sv
//==============================================================================
// Module   : tb_max_pool_engine
// Purpose  : Self-checking bench for max_pool_engine. Two instances (stride 1
//            and stride 2, K=3, N=5) share one window stream; a reference
//            model derives expected outputs from the raster position.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_max_pool_engine;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int N  = 5;
  localparam int NI = 2;                     // instance i has stride i+1
  localparam int FIRST_LIN = (K - 1) * N + (K - 1);
  localparam int WRAP_LIN  = (K - 1) * N;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [K-1:0][K-1:0][DW-1:0] window;
  logic                        window_valid;
  logic [DW-1:0]               pout  [NI];
  logic                        pval  [NI];
  logic                        plast [NI];

  always #5 clk = ~clk;

  max_pool_engine #(.DATA_WIDTH(DW), .KERNEL_DIM(K), .ROW_SIZE(N), .STRIDE(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .window(window), .window_valid(window_valid),
    .pool_out(pout[0]), .pool_valid(pval[0]), .pool_last(plast[0])
  );

  max_pool_engine #(.DATA_WIDTH(DW), .KERNEL_DIM(K), .ROW_SIZE(N), .STRIDE(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .window(window), .window_valid(window_valid),
    .pool_out(pout[1]), .pool_valid(pval[1]), .pool_last(plast[1])
  );

  // Model state: raster position of the next window and a 2-deep expectation pipe.
  int          lin;
  logic        ev [NI][2];
  logic        el [NI][2];
  logic [DW-1:0] ed [NI][2];
  int          pix [N*N];
  int          outcnt [NI];
  logic [DW-1:0] seq0 [$];
  int          checks = 0;
  int          errors = 0;
  logic        use_custom = 1'b0;
  logic [K-1:0][K-1:0][DW-1:0] custom_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic [DW-1:0] win_max(input logic [K-1:0][K-1:0][DW-1:0] w);
    logic [DW-1:0] m;
    m = w[0][0];
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        if (greater(w[i][j], m)) m = w[i][j];
    return m;
  endfunction

  // One clock step: check outputs due now, then drive the next window.
  task automatic tick(input logic v, input logic r);
    int row, col, s, od, pl;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("valid_s%0d", i + 1), 32'(pval[i]), 32'(ev[i][1]));
      chk($sformatf("last_s%0d", i + 1), 32'(plast[i]), 32'(el[i][1]));
      if (ev[i][1]) chk($sformatf("data_s%0d", i + 1), 32'(pout[i]), 32'(ed[i][1]));
      if (pval[i] === 1'b1) outcnt[i]++;
      if (i == 0 && pval[0] === 1'b1 && seq0.size() < 9) seq0.push_back(pout[0]);
      ev[i][1] = ev[i][0]; el[i][1] = el[i][0]; ed[i][1] = ed[i][0];
      ev[i][0] = 1'b0;     el[i][0] = 1'b0;     ed[i][0] = '0;
    end
    row = lin / N;
    col = lin % N;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        window[i][j] = (col >= K - 1) ? DW'(pix[(row - (K - 1) + i) * N + col - (K - 1) + j])
                                      : DW'($urandom);
    if (use_custom) window = custom_win;
    rst          = r;
    window_valid = v;
    if (r) begin
      #1;
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("rst_valid_s%0d", i + 1), 32'(pval[i]), 32'd0);
        chk($sformatf("rst_last_s%0d", i + 1), 32'(plast[i]), 32'd0);
        chk($sformatf("rst_out_s%0d", i + 1), 32'(pout[i]), 32'd0);
        ev[i][1] = 1'b0; el[i][1] = 1'b0;
      end
      lin = FIRST_LIN;
    end else if (v) begin
      for (int i = 0; i < NI; i++) begin
        s  = i + 1;
        od = (N - K) / s + 1;
        pl = K - 1 + (od - 1) * s;
        if (col >= K - 1 && (col - (K - 1)) % s == 0 && (row - (K - 1)) % s == 0) begin
          ev[i][0] = 1'b1;
          ed[i][0] = win_max(window);
          el[i][0] = (row == pl) && (col == pl);
        end
      end
      lin = (lin == N * N - 1) ? WRAP_LIN : lin + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: pixels base, base+1, ...; mode 1: random pixels.
  task automatic run_frame(input int mode, input int base, input int gmax);
    int steps;
    for (int p = 0; p < N * N; p++) pix[p] = (mode == 0) ? base + p : int'($urandom_range(0, 255));
    steps = N * N - lin;
    for (int s = 0; s < steps; s++) begin
      repeat ($urandom_range(0, gmax)) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
    end
  endtask

  initial begin
    int exp_seq [9] = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    int base0;
    int steps;
    logic [DW-1:0] signed_exp;

    lin = FIRST_LIN;
    for (int i = 0; i < NI; i++) begin
      outcnt[i] = 0;
      for (int d = 0; d < 2; d++) begin ev[i][d] = 0; el[i][d] = 0; ed[i][d] = '0; end
    end
    for (int p = 0; p < N * N; p++) pix[p] = 0;
    rst = 1'b1; window_valid = 1'b0; window = '0; custom_win = '0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_valid_s%0d", i + 1), 32'(pval[i]), 32'd0);
      chk($sformatf("reset_last_s%0d", i + 1), 32'(plast[i]), 32'd0);
      chk($sformatf("reset_out_s%0d", i + 1), 32'(pout[i]), 32'd0);
    end
    tick(1'b0, 1'b0);

    // Two frames back to back: 1..25 then 26..50, no gaps.
    run_frame(0, 1, 0);
    run_frame(0, 26, 0);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("count_s1_two_frames", 32'(outcnt[0]), 32'd18);
    chk("count_s2_two_frames", 32'(outcnt[1]), 32'd8);
    for (int k = 0; k < 9; k++)
      chk($sformatf("frame1_seq_%0d", k), (k < seq0.size()) ? 32'(seq0[k]) : 32'hFFFF_FFFF,
          32'(exp_seq[k]));

    // Same stream with random idle gaps.
    run_frame(0, 1, 3);
    // Random pixel frames with gaps.
    repeat (3) run_frame(1, 0, 3);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);

    // Reset mid-frame after the 4th stride-1 output, then a fresh frame.
    base0 = outcnt[0];
    for (int p = 0; p < N * N; p++) pix[p] = p + 1;
    steps = N * N - lin;
    for (int s = 0; s < steps && (outcnt[0] - base0) < 4; s++) tick(1'b1, 1'b0);
    chk("outputs_before_midreset", 32'(outcnt[0] - base0), 32'd4);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    base0 = outcnt[0];
    run_frame(0, 1, 0);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("count_s1_after_reset", 32'(outcnt[0] - base0), 32'd9);

    // Signedness: one window holding 8'hFF and 8'h01, others 0.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    custom_win = '0;
    custom_win[0][1] = 8'hFF;
    custom_win[2][0] = 8'h01;
    use_custom = 1'b1;
    tick(1'b1, 1'b0);
    use_custom = 1'b0;
    tick(1'b0, 1'b0);
`ifdef MAXPOOL_SIGNED_EN
    signed_exp = 8'h01;
`else
    signed_exp = 8'hFF;
`endif
    chk("sign_valid", 32'(pval[0]), 32'd1);
    chk("sign_max", 32'(pout[0]), 32'(signed_exp));
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/max_pool_engine.md
# max_pool_engine

- Consumes the K×K window stream produced by `sliding_window` and performs max pooling.
- Discards windows that straddle a row boundary and applies a configurable stride.
- Reduces each accepted window to its maximum through a two-stage registered comparator tree.
- Emits one pooled pixel per accepted window, in raster order, with an end-of-frame marker for the downstream writer.

## Interface

Parameters:
- `DATA_WIDTH`, 8, pixel width in bits.
- `KERNEL_DIM`, 3, window edge K; must match the upstream `sliding_window`.
- `ROW_SIZE`, 5, input image edge N (square frame); must match upstream.
- `STRIDE`, 1, pooling stride S, ≥1. Elaboration fails unless ROW_SIZE ≥ KERNEL_DIM and STRIDE ≥ 1.
- Derived `OUT_DIM` = (ROW_SIZE−KERNEL_DIM)/STRIDE + 1 (integer division). Outputs per frame = OUT_DIM².

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `window`  in  DATA_WIDTH × [KERNEL_DIM][KERNEL_DIM]  current window; `window[r][c]`, row 0 = oldest image row.
- `window_valid`  in  1  window is populated. One assertion is one raster step of the window.
- `pool_out`  out  DATA_WIDTH  maximum of an accepted window.
- `pool_valid`  out  1  `pool_out` is valid this cycle.
- `pool_last`  out  1  qualifies the final pooled pixel of a frame. Only high together with `pool_valid`.

## Operation

Upstream contract:
- The first `window_valid` after reset has its bottom-right element at input (row K−1, col K−1).
- Each later `window_valid` cycle advances that position by exactly one input pixel in raster order, including wrap positions.
- Gaps (valid low) are allowed. Counters advance only on `window_valid`.

Position tracking:
- `col_cnt` runs 0..N−1 and starts at K−1 after reset.
- `row_cnt` runs K−1..N−1 and starts at K−1.
- On each `window_valid`, `col_cnt` increments. It wraps from N−1 to 0 and increments `row_cnt` at the wrap.
- After (row N−1, col N−1), `row_cnt` returns to K−1 and `col_cnt` to 0. This wrapped state is the phase of the next frame's first streamed pixel.

Stride phase:
- `col_ph` and `row_ph` count 0..S−1.
- `col_ph` resets to 0 whenever `col_cnt` = K−1 is reached.
- `row_ph` resets at the start of each frame.
- No divider or modulo logic is used.

Accept rule:
- A window is accepted when `window_valid` && `col_cnt` ≥ K−1 && `col_ph` == 0 && `row_ph` == 0.
- Windows with `col_cnt` < K−1 straddle two image rows and are dropped silently.

Reduction:
- Stage 1 registers K row maxima, each over K elements. Stage 2 registers the maximum of those K values.
- Comparison is unsigned by default (see Configuration).
- Ties produce the common value. Output width equals DATA_WIDTH; there is no growth.

Last flag:
- `pool_last` is tagged at accept time when (`row_cnt`, `col_cnt`) is the final accepted position of the frame.
- That position is row K−1+(OUT_DIM−1)·S, col K−1+(OUT_DIM−1)·S.
- The tag travels down the pipeline with the data.

## Timing

- Reset values: `pool_out`=0, `pool_valid`=0, `pool_last`=0.
- Reset also returns all pipeline valid bits to 0, `col_cnt`/`row_cnt` to K−1, and phases to 0.
- Latency: a window accepted at edge t appears with `pool_valid` high after edge t+2. Fixed, no stall.
- Throughput: one window per cycle. There is no backpressure; the downstream must accept every `pool_valid`.
- Back-to-back accepts give back-to-back `pool_valid`. Dropped or gapped windows give bubbles.
- Reset mid-frame: in-flight results are discarded, no `pool_valid` pulses, and counters restart at (K−1, K−1).
- While `rst` is high, `window_valid` is ignored.
- Frame boundary: the last window of frame F and the first of frame F+1 may arrive on consecutive cycles. Both are handled without loss.
- K = N: exactly one output per frame, with `pool_last` high.

## Configuration

- `MAXPOOL_SIGNED_EN` defined: all comparisons treat pixels as two's-complement signed, so 8'hFF (−1) < 8'h01.
- Not defined: comparisons are unsigned, so 8'hFF > 8'h01.
- Ports, latency and counters are identical in both builds.

## Test plan

- K=3, N=5, S=1; stream 1..25 through `sliding_window`. Expect exactly 9 outputs: 13,14,15,18,19,20,23,24,25. `pool_last` only on 25. Windows at col 0/1 are dropped.
- Same stimulus with S=2. Expect 4 outputs, 13,15,23,25, with `pool_last` on 25.
- Random idle gaps (0–3 cycles) on `window_valid` with the 1..25 stream. Expect the same 9 values in order, each 2 cycles after its accepting window.
- Two frames back-to-back (1..25 then 26..50). Expect the second frame to yield 38,39,40,43,44,45,48,49,50, with `pool_last` on 25 and 50.
- Assert `rst` for one cycle after the 4th output. Expect outputs to go 0/low immediately and no stale `pool_valid`. A fresh 1..25 frame then yields all 9 values.
- Window containing 8'hFF and 8'h01 (others 0). Expect 8'hFF without `MAXPOOL_SIGNED_EN` and 8'h01 with it.
